pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Central hazard/forwarding controller for the 5-stage pipelined CPU; generalises the fixed
//   IF/ID/EX/MEM/WB datapath with stall, flush and bypass control it currently lacks.
// - Tracks destination register, load flag and valid bit of every in-flight instruction past
//   ID in an internal stage shift register.
// - Drives PC/IF_ID hold, ID_EX bubble insert, IF_ID flush on taken branch, EX operand
//   forwarding selects and saturating stall/flush event counters.
// PARAMETERS
// - DEPTH     3   tracked stages after ID (0=EX,1=MEM,2=WB); legal 2..6
// - RA_W      5   register address width
// - FWD_EN    1   1: bypass from stages 1..DEPTH-1; 0: no bypass, stall until retire
// - CNT_W     16  event counter width
// - FSEL_W    $clog2(DEPTH) forwarding select width (derived, do not override)
// PORTS
// - clk_i          in   1       clock, rising edge
// - rst_n          in   1       asynchronous active-low reset
// - id_valid_i     in   1       ID holds a real instruction
// - id_rs_i        in   RA_W    ID source A
// - id_rt_i        in   RA_W    ID source B
// - id_use_rs_i    in   1       ID reads rs
// - id_use_rt_i    in   1       ID reads rt
// - id_wr_en_i     in   1       ID writes register file
// - id_wr_addr_i   in   RA_W    ID destination (already RT/RD muxed)
// - id_is_load_i   in   1       ID is a load
// - ex_br_taken_i  in   1       branch in EX resolved taken
// - stall_o        out  1       hold PC and IF_ID this cycle
// - bubble_o       out  1       load NOP into ID_EX this cycle
// - flush_o        out  1       replace IF_ID contents with NOP this cycle
// - fwd_a_o        out  FSEL_W  EX operand A source: 0=reg file, k=stage k result
// - fwd_b_o        out  FSEL_W  EX operand B source, same encoding
// - stall_cnt_o    out  CNT_W   cycles with stall_o=1, saturating
// - flush_cnt_o    out  CNT_W   cycles with flush_o=1, saturating
// BEHAVIOUR
// - Reset (async, rst_n=0): all slot valid=0, counters=0; hence all outputs 0 while in reset
//   and in the first cycle after release. Reset mid-operation discards all tracking at once.
// - Slot i holds {valid, wr_en, wr_addr, is_load, rs, rt, use_rs, use_rt}. Each rising edge:
//   slot[i+1]<=slot[i]; slot[DEPTH-1] retires. Slot[0] <= ID fields, or valid=0 if bubble_o.
// - Producer match(i,r): slot[i].valid & wr_en & wr_addr==r & r!=0. Register 0 never hazards.
// - FWD_EN=1 stall: ID needs r (use & id_valid) and match(0,r) with slot[0].is_load (load-use);
//   exactly one stall cycle per load-use pair.
// - FWD_EN=0 stall: ID needs r and match(i,r) for any i in 0..DEPTH-1 (reg file not
//   write-through; consumer proceeds the cycle after producer leaves WB slot).
// - bubble_o = stall_o | flush_o. All three outputs combinational from current slots/inputs.
// - flush_o = ex_br_taken_i & slot[0].valid. Flush has priority: when flush_o=1, stall_o=0
//   (younger instruction is killed anyway).
// - Forwarding (FWD_EN=1): for EX consumer slot[0], fwd_a_o = smallest k in 1..DEPTH-1 with
//   match(k, slot[0].rs) & slot[0].use_rs, else 0 (youngest producer wins). fwd_b_o likewise
//   on rt. Load in slot 1 never forwards as its result is available only from slot 2 onward;
//   search skips it. FWD_EN=0: fwd_a_o=fwd_b_o=0 always.
// - Forward outputs are 0 when slot[0].valid=0.
// - Counters increment by 1 per qualifying cycle; hold at 2^CNT_W-1; never wrap.
// STRUCTURE
// - pipe_pkg: slot record typedef, FWD_RF=0 constant, stage index constants (EX/MEM/WB).
// - One sub-module: pipe_sat_counter (CNT_W, inc_i, count_o), instantiated twice.
// - Slot array, match/priority search in generate loops over DEPTH.
// TESTING
// - Default params, ADD r3 then SUB r4,r3,r1 back-to-back -> no stall; SUB in EX sees fwd_a_o=1.
// - ADD r3; NOP; AND r5,r3,r3 -> fwd_a_o=2, fwd_b_o=2 when AND in EX; stall_o never 1.
// - LW r2; ADD r6,r2,r2 -> stall_o=bubble_o=1 one cycle, then ADD in EX with fwd_a_o=2;
//   stall_cnt_o=1.
// - ADD r0 producer then reader of r0 -> no stall, fwd selects 0; FWD_EN=0 with ADD r7
//   then OR r8,r7 -> 3 stall cycles, fwd 0.
// - Branch taken while LW/use pair in IF/ID -> flush_o=1, stall_o=0, flush_cnt_o=1; assert
//   rst_n=0 mid-sequence -> all outputs 0 immediately; force 2^CNT_W+5 stalls -> counter saturates.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types, constants and helpers for the pipeline hazard/forwarding controller.
package pipe_pkg;

  // Widest register address a slot can hold; narrower addresses are zero-extended.
  localparam int RA_W_MAX = 8;

  // Forwarding select value meaning "read the register file".
  localparam int FWD_RF = 0;

  // Tracked stage indices after ID.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef logic [RA_W_MAX-1:0] reg_addr_t;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic      valid;
    logic      wr_en;
    reg_addr_t wr_addr;
    logic      is_load;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      use_rs;
    logic      use_rt;
  } slot_t;

  // A slot produces register r if it is live, writes, targets r, and r is not r0.
  function automatic logic producer_match(input slot_t s, input reg_addr_t r);
    return s.valid && s.wr_en && (s.wr_addr == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle of the controller.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W   = 5,
  parameter int FSEL_W = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic [RA_W-1:0]   id_rs_i;
  logic [RA_W-1:0]   id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic              id_wr_en_i;
  logic [RA_W-1:0]   id_wr_addr_i;
  logic              id_is_load_i;
  logic              ex_br_taken_i;
  logic              stall_o;
  logic              bubble_o;
  logic              flush_o;
  logic [FSEL_W-1:0] fwd_a_o;
  logic [FSEL_W-1:0] fwd_b_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  // Pipeline datapath side: presents ID state, consumes control.
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_wr_en_i, id_wr_addr_i, id_is_load_i, ex_br_taken_i,
    input  stall_o, bubble_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_wr_en_i, id_wr_addr_i, id_is_load_i, ex_br_taken_i,
    output stall_o, bubble_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts qualifying cycles and sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  // Increment on each qualifying cycle unless already at the maximum.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: tracks instructions
// past ID, generates stall/bubble/flush and EX operand bypass selects.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  parameter int FSEL_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  slot_t             slots [DEPTH];
  slot_t             id_slot;
  logic [DEPTH-1:0]  id_hit_rs;
  logic [DEPTH-1:0]  id_hit_rt;
  logic [DEPTH-1:1]  ex_hit_rs;
  logic [DEPTH-1:1]  ex_hit_rt;
  logic              need_rs;
  logic              need_rt;
  logic              raw_stall;
  logic              stall;
  logic              flush;
  logic              bubble;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;

  // Pack the ID-stage instruction into slot form.
  always_comb begin
    id_slot         = '0;
    id_slot.valid   = bus.id_valid_i;
    id_slot.wr_en   = bus.id_wr_en_i;
    id_slot.wr_addr = reg_addr_t'(bus.id_wr_addr_i[RA_W-1:0]);
    id_slot.is_load = bus.id_is_load_i;
    id_slot.rs      = reg_addr_t'(bus.id_rs_i[RA_W-1:0]);
    id_slot.rt      = reg_addr_t'(bus.id_rt_i[RA_W-1:0]);
    id_slot.use_rs  = bus.id_use_rs_i;
    id_slot.use_rt  = bus.id_use_rt_i;
  end

  // Advance the stage shift register; a bubble enters EX as an empty slot.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are few and feed hazard logic directly, so every field is cleared rather than just valid, keeping X out of the compares.
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      // NOTE: non-blocking updates make each slot take its neighbour's pre-edge value, so loop order does not matter.
      slots[STG_EX] <= bubble ? '0 : id_slot;
      for (int i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
    end
  end

  // Producer matches against the ID sources and against the EX consumer sources.
  for (genvar g = 0; g < DEPTH; g++) begin : g_id_hit
    assign id_hit_rs[g] = producer_match(slots[g], id_slot.rs);
    assign id_hit_rt[g] = producer_match(slots[g], id_slot.rt);
  end

  for (genvar g = 1; g < DEPTH; g++) begin : g_ex_hit
    assign ex_hit_rs[g] = producer_match(slots[g], slots[STG_EX].rs);
    assign ex_hit_rt[g] = producer_match(slots[g], slots[STG_EX].rt);
  end

  assign need_rs = bus.id_valid_i & bus.id_use_rs_i;
  assign need_rt = bus.id_valid_i & bus.id_use_rt_i;

  // Stall detection: load-use only with bypass, any in-flight producer without it.
  always_comb begin
    if (FWD_EN != 0) begin
      raw_stall = slots[STG_EX].is_load &
                  ((need_rs & id_hit_rs[STG_EX]) | (need_rt & id_hit_rt[STG_EX]));
    end else begin
      raw_stall = (need_rs & (|id_hit_rs)) | (need_rt & (|id_hit_rt));
    end
  end

  // A taken branch kills the younger ID instruction, so it overrides any stall.
  assign flush  = bus.ex_br_taken_i & slots[STG_EX].valid;
  assign stall  = raw_stall & ~flush;
  assign bubble = stall | flush;

  // Operand bypass: scan oldest to youngest so the youngest producer is kept.
  always_comb begin
    // NOTE: defaults first so every path assigns both selects and no latch is inferred.
    fwd_a = FSEL_W'(FWD_RF);
    fwd_b = FSEL_W'(FWD_RF);
    if ((FWD_EN != 0) && slots[STG_EX].valid) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        // A load's data exists only from the WB slot onward.
        if (!((k < STG_WB) && slots[k].is_load)) begin
          if (ex_hit_rs[k] && slots[STG_EX].use_rs) fwd_a = FSEL_W'(k);
          if (ex_hit_rt[k] && slots[STG_EX].use_rt) fwd_b = FSEL_W'(k);
        end
      end
    end
  end

  assign bus.stall_o  = stall;
  assign bus.bubble_o = bubble;
  assign bus.flush_o  = flush;
  assign bus.fwd_a_o  = fwd_a;
  assign bus.fwd_b_o  = fwd_b;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .inc_i   (stall),
    .count_o (bus.stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .inc_i   (flush),
    .count_o (bus.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a bypassing instance with 16-bit
// counters and a non-bypassing instance with 3-bit counters.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RA_W(5), .FSEL_W(2), .CNT_W(16)) bus_a ();
  pipe_hazard_ctrl_if #(.RA_W(5), .FSEL_W(2), .CNT_W(3))  bus_b ();

  pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .FWD_EN(1), .CNT_W(16)) dut_a (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .FWD_EN(0), .CNT_W(3)) dut_b (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wr_en;
    logic [4:0] wr;
    logic       ld;
  } instr_t;

  typedef struct {
    string       name;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic instr_t nop();
    instr_t i = '{default: '0};
    return i;
  endfunction

  function automatic instr_t alu(input int d, input int s, input int t);
    instr_t i = '{default: '0};
    i.valid = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.use_rs = 1'b1; i.use_rt = 1'b1;
    i.wr_en = 1'b1; i.wr = 5'(d);
    return i;
  endfunction

  function automatic instr_t lw(input int d, input int b);
    instr_t i = '{default: '0};
    i.valid = 1'b1; i.rs = 5'(b); i.use_rs = 1'b1;
    i.wr_en = 1'b1; i.wr = 5'(d); i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t beq(input int s, input int t);
    instr_t i = '{default: '0};
    i.valid = 1'b1; i.rs = 5'(s); i.rt = 5'(t); i.use_rs = 1'b1; i.use_rt = 1'b1;
    return i;
  endfunction

  function automatic exp_t ex(input string n, input int st, input int bu, input int fl,
                              input int fa, input int fb, input int sc, input int fc);
    exp_t e;
    e.name = n; e.stall = 1'(st); e.bubble = 1'(bu); e.flush = 1'(fl);
    e.fa = 2'(fa); e.fb = 2'(fb); e.sc = 16'(sc); e.fc = 16'(fc);
    return e;
  endfunction

  function automatic int sat3(input int n);
    return (n > 7) ? 7 : n;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_outputs(input exp_t e, input logic st, input logic bu, input logic fl,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [15:0] sc, input logic [15:0] fc);
    check({e.name, ".stall"},  16'(st), 16'(e.stall));
    check({e.name, ".bubble"}, 16'(bu), 16'(e.bubble));
    check({e.name, ".flush"},  16'(fl), 16'(e.flush));
    check({e.name, ".fwd_a"},  16'(fa), 16'(e.fa));
    check({e.name, ".fwd_b"},  16'(fb), 16'(e.fb));
    check({e.name, ".stall_cnt"}, sc, e.sc);
    check({e.name, ".flush_cnt"}, fc, e.fc);
  endtask

  task automatic drive_a(input instr_t i, input logic br, input logic rst, input exp_t e);
    bus_a.id_valid_i   = i.valid;
    bus_a.id_rs_i      = i.rs;
    bus_a.id_rt_i      = i.rt;
    bus_a.id_use_rs_i  = i.use_rs;
    bus_a.id_use_rt_i  = i.use_rt;
    bus_a.id_wr_en_i   = i.wr_en;
    bus_a.id_wr_addr_i = i.wr;
    bus_a.id_is_load_i = i.ld;
    bus_a.ex_br_taken_i = br;
    rst_n = rst;
    qa.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input instr_t i, input exp_t e);
    bus_b.id_valid_i   = i.valid;
    bus_b.id_rs_i      = i.rs;
    bus_b.id_rt_i      = i.rt;
    bus_b.id_use_rs_i  = i.use_rs;
    bus_b.id_use_rt_i  = i.use_rt;
    bus_b.id_wr_en_i   = i.wr_en;
    bus_b.id_wr_addr_i = i.wr;
    bus_b.id_is_load_i = i.ld;
    bus_b.ex_br_taken_i = 1'b0;
    qb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each cycle's outputs against the expectation queued for it.
  always @(negedge clk) begin
    if (qa.size() != 0) begin
      exp_t e;
      e = qa.pop_front();
      check_outputs(e, bus_a.stall_o, bus_a.bubble_o, bus_a.flush_o, bus_a.fwd_a_o,
                    bus_a.fwd_b_o, bus_a.stall_cnt_o, bus_a.flush_cnt_o);
    end
  end

  always @(negedge clk) begin
    if (qb.size() != 0) begin
      exp_t e;
      e = qb.pop_front();
      check_outputs(e, bus_b.stall_o, bus_b.bubble_o, bus_b.flush_o, bus_b.fwd_a_o,
                    bus_b.fwd_b_o, 16'(bus_b.stall_cnt_o), 16'(bus_b.flush_cnt_o));
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus_a.id_valid_i = 1'b0; bus_a.id_rs_i = '0; bus_a.id_rt_i = '0;
    bus_a.id_use_rs_i = 1'b0; bus_a.id_use_rt_i = 1'b0; bus_a.id_wr_en_i = 1'b0;
    bus_a.id_wr_addr_i = '0; bus_a.id_is_load_i = 1'b0; bus_a.ex_br_taken_i = 1'b0;
    bus_b.id_valid_i = 1'b0; bus_b.id_rs_i = '0; bus_b.id_rt_i = '0;
    bus_b.id_use_rs_i = 1'b0; bus_b.id_use_rt_i = 1'b0; bus_b.id_wr_en_i = 1'b0;
    bus_b.id_wr_addr_i = '0; bus_b.id_is_load_i = 1'b0; bus_b.ex_br_taken_i = 1'b0;
    @(posedge clk);
    #1;

    // Held in reset with a taken branch and a reader in ID: nothing may fire.
    drive_a(alu(6, 2, 2), 1'b1, 1'b0, ex("reset", 0, 0, 0, 0, 0, 0, 0));

    // ADD r3 ; SUB r4,r3,r1 back-to-back.
    drive_a(alu(3, 1, 2), 1'b0, 1'b1, ex("add_r3_first", 0, 0, 0, 0, 0, 0, 0));
    drive_a(alu(4, 3, 1), 1'b0, 1'b1, ex("sub_in_id", 0, 0, 0, 0, 0, 0, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("sub_in_ex", 0, 0, 0, 1, 0, 0, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("drain_1", 0, 0, 0, 0, 0, 0, 0));

    // ADD r3 ; NOP ; AND r5,r3,r3.
    drive_a(alu(3, 1, 2), 1'b0, 1'b1, ex("add_r3_again", 0, 0, 0, 0, 0, 0, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("gap_nop", 0, 0, 0, 0, 0, 0, 0));
    drive_a(alu(5, 3, 3), 1'b0, 1'b1, ex("and_in_id", 0, 0, 0, 0, 0, 0, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("and_in_ex", 0, 0, 0, 2, 2, 0, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("drain_2", 0, 0, 0, 0, 0, 0, 0));

    // LW r2 ; ADD r6,r2,r2 -> one stall, then forward from WB slot.
    drive_a(lw(2, 1),     1'b0, 1'b1, ex("lw_in_id", 0, 0, 0, 0, 0, 0, 0));
    drive_a(alu(6, 2, 2), 1'b0, 1'b1, ex("load_use_stall", 1, 1, 0, 0, 0, 0, 0));
    drive_a(alu(6, 2, 2), 1'b0, 1'b1, ex("load_use_release", 0, 0, 0, 0, 0, 1, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("load_use_fwd", 0, 0, 0, 2, 2, 1, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("drain_3", 0, 0, 0, 0, 0, 1, 0));

    // LW r0 ; OR r9,r0,r0 ; AND r10,r0,r0 -> r0 never stalls or forwards.
    drive_a(lw(0, 1),      1'b0, 1'b1, ex("lw_r0", 0, 0, 0, 0, 0, 1, 0));
    drive_a(alu(9, 0, 0),  1'b0, 1'b1, ex("r0_no_stall", 0, 0, 0, 0, 0, 1, 0));
    drive_a(alu(10, 0, 0), 1'b0, 1'b1, ex("r0_slot1", 0, 0, 0, 0, 0, 1, 0));
    drive_a(nop(),         1'b0, 1'b1, ex("r0_no_fwd", 0, 0, 0, 0, 0, 1, 0));
    drive_a(nop(),         1'b0, 1'b1, ex("drain_4", 0, 0, 0, 0, 0, 1, 0));

    // Taken branch in EX with LW in ID: flush, no stall.
    drive_a(beq(1, 2),    1'b0, 1'b1, ex("beq_in_id", 0, 0, 0, 0, 0, 1, 0));
    drive_a(lw(2, 1),     1'b1, 1'b1, ex("branch_flush", 0, 1, 1, 0, 0, 1, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("after_flush", 0, 0, 0, 0, 0, 1, 1));

    // Flush overrides a live load-use stall.
    drive_a(lw(2, 1),     1'b0, 1'b1, ex("lw_again", 0, 0, 0, 0, 0, 1, 1));
    drive_a(alu(6, 2, 2), 1'b1, 1'b1, ex("flush_over_stall", 0, 1, 1, 0, 0, 1, 1));
    drive_a(nop(),        1'b0, 1'b1, ex("after_prio", 0, 0, 0, 0, 0, 1, 2));
    drive_a(nop(),        1'b0, 1'b1, ex("drain_5", 0, 0, 0, 0, 0, 1, 2));

    // Reset asserted with a load-use pair pending clears everything at once.
    drive_a(lw(2, 1),     1'b0, 1'b1, ex("pre_reset", 0, 0, 0, 0, 0, 1, 2));
    drive_a(alu(6, 2, 2), 1'b0, 1'b0, ex("mid_reset", 0, 0, 0, 0, 0, 0, 0));
    drive_a(alu(6, 2, 2), 1'b0, 1'b1, ex("post_reset", 0, 0, 0, 0, 0, 0, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("post_reset_ex", 0, 0, 0, 0, 0, 0, 0));
    drive_a(nop(),        1'b0, 1'b1, ex("drain_6", 0, 0, 0, 0, 0, 0, 0));

    // No-bypass instance: ADD r7 ; OR r8,r7 stalls three cycles per pair;
    // five pairs push the 3-bit stall counter past saturation.
    n = 0;
    for (int p = 0; p < 5; p++) begin
      drive_b(alu(7, 1, 2), ex("nb_add_r7",   0, 0, 0, 0, 0, sat3(n),     0));
      drive_b(alu(8, 7, 0), ex("nb_stall_ex", 1, 1, 0, 0, 0, sat3(n),     0));
      drive_b(alu(8, 7, 0), ex("nb_stall_mem", 1, 1, 0, 0, 0, sat3(n + 1), 0));
      drive_b(alu(8, 7, 0), ex("nb_stall_wb", 1, 1, 0, 0, 0, sat3(n + 2), 0));
      drive_b(alu(8, 7, 0), ex("nb_issue",    0, 0, 0, 0, 0, sat3(n + 3), 0));
      n += 3;
    end
    drive_b(nop(), ex("nb_saturated", 0, 0, 0, 0, 0, 7, 0));

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
